// File: rtl/uart_tx_arb_if.sv
// uart_tx_arb_if: requester byte streams plus the shared UART transmit channel for uart_tx_arb
interface uart_tx_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int IDW = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0] req_valid, req_last, req_ready;
  logic [8*NUM_REQ-1:0] req_data;
  logic [7:0] tx_data;
  logic tx_valid, tx_ready, busy;
  logic [IDW-1:0] grant_id;
  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input req_ready, tx_data, tx_valid, grant_id, busy
  );
  modport slave (
    input req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_data, tx_valid, grant_id, busy
  );
endinterface

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin packet arbiter onto one UART tx channel; defining UART_ARB_HDR_EN adds a {4'hA,id} header byte per grant
module uart_tx_arb #(
  parameter int NUM_REQ = 4,
  parameter int MAX_BURST = 16,
  parameter int IDW = $clog2(NUM_REQ)
) (
  input logic clk,
  input logic rst,
  uart_tx_arb_if.slave bus
);
  localparam int CW = $clog2(MAX_BURST) + 1;
  typedef enum logic [1:0] {IDLE, BURST, HDR} state_t;
  state_t state_q, state_d;
  logic [IDW-1:0] grant_q, grant_d, rr_q, rr_d, pick, j;
  logic [CW-1:0] cnt_q, cnt_d;
  logic busy_q, busy_d, found, xfer, done;
  always_comb begin
    pick = rr_q;
    found = 1'b0;
    j = rr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = IDW'((int'(rr_q) + k) % NUM_REQ);
      if (!found && bus.req_valid[j]) begin
        pick = j;
        found = 1'b1;
      end
    end
  end
  assign xfer = state_q == BURST && bus.req_valid[grant_q] && bus.tx_ready;
  assign done = xfer && (bus.req_last[grant_q] || cnt_q == CW'(MAX_BURST - 1));
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d = rr_q;
    cnt_d = xfer ? cnt_q + 1'b1 : cnt_q;
    busy_d = busy_q;
    if (state_q == IDLE && found) begin
      grant_d = pick;
      cnt_d = '0;
      busy_d = 1'b1;
`ifdef UART_ARB_HDR_EN
      state_d = HDR;
`else
      state_d = BURST;
`endif
    end
    if (state_q == HDR && bus.tx_ready) state_d = BURST;
    if (done) begin
      state_d = IDLE;
      rr_d = grant_q == IDW'(NUM_REQ - 1) ? '0 : grant_q + 1'b1;
      busy_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q <= rr_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
    end
  end
  assign bus.tx_valid = state_q == BURST ? bus.req_valid[grant_q] : state_q == HDR;
  assign bus.tx_data = state_q == BURST ? bus.req_data[{grant_q, 3'b000} +: 8] :
                       state_q == HDR ? {4'hA, 4'(grant_q)} : 8'h00;
  assign bus.req_ready = (state_q == BURST && bus.tx_ready) ? NUM_REQ'(1) << grant_q : '0;
  assign bus.grant_id = grant_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed self-checking bench for uart_tx_arb
module tb_uart_tx_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int xfers = 0;
  int n0;
  uart_tx_arb_if #(.NUM_REQ(4), .IDW(2)) bus();
  uart_tx_arb #(.NUM_REQ(4), .MAX_BURST(16), .IDW(2)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.tx_valid && bus.tx_ready) xfers++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #3;
  endtask
  task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
    bus.req_valid[i] = v;
    bus.req_data[8*i +: 8] = d;
    bus.req_last[i] = l;
  endtask
  task automatic do_reset();
    bus.req_valid = '0;
    bus.req_last = '0;
    bus.req_data = '0;
    bus.tx_ready = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask
  task automatic do_grant(input int id);
    step();
    chk("grant_id", bus.grant_id, id);
    chk("grant_busy", bus.busy, 1);
`ifdef UART_ARB_HDR_EN
    chk("hdr_data", bus.tx_data, 32'hA0 | id);
    chk("hdr_ready", bus.req_ready, 0);
    step();
`endif
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    // reset with every requester valid, then req0 two-byte packet
    bus.tx_ready = 1'b1;
    set_req(0, 1, 8'h11, 0);
    set_req(1, 1, 8'h31, 1);
    set_req(2, 1, 8'h32, 1);
    set_req(3, 1, 8'h33, 1);
    step();
    step();
    chk("rst_tx_valid", bus.tx_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_grant", bus.grant_id, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    rst = 1'b0;
    #1;
    chk("bubble_valid", bus.tx_valid, 0);
    do_grant(0);
    chk("p0_valid", bus.tx_valid, 1);
    chk("p0_b0", bus.tx_data, 8'h11);
    chk("p0_ready", bus.req_ready, 4'b0001);
    step();
    set_req(0, 1, 8'h22, 1);
    #1;
    chk("p0_b1", bus.tx_data, 8'h22);
    step();
    set_req(0, 0, 8'h00, 0);
    #1;
    chk("p0_release_busy", bus.busy, 0);
    chk("p0_release_valid", bus.tx_valid, 0);
    chk("p0_release_grant", bus.grant_id, 0);
    do_grant(1);
    chk("p1_b0", bus.tx_data, 8'h31);
    // four single-byte packets rotate 0..3 with one idle cycle between
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1, 8'(8'h40 + i), 1);
    for (int i = 0; i < 4; i++) begin
      do_grant(i);
      chk("rr_data", bus.tx_data, 8'h40 + i);
      step();
      set_req(i, 0, 8'h00, 0);
      #1;
      chk("rr_gap", bus.tx_valid, 0);
    end
    // 20-byte stream forced off after 16; v=1 has req3 pending
    for (int v = 0; v < 2; v++) begin
      do_reset();
      set_req(2, 1, 8'd1, 0);
      do_grant(2);
      set_req(3, v[0], 8'h77, 1);
      #1;
      n0 = xfers;
      for (int b = 0; b < 16; b++) begin
        chk("burst_data", bus.tx_data, b + 1);
        step();
        set_req(2, 1, 8'(b + 2), 0);
        #1;
      end
      chk("burst_count", xfers - n0, 16);
      chk("burst_release", bus.busy, 0);
      chk("burst_idle_valid", bus.tx_valid, 0);
      do_grant(v == 1 ? 3 : 2);
      chk("burst_next_data", bus.tx_data, v == 1 ? 32'h77 : 32'd17);
    end
    // granted requester pauses 5 cycles while req1 waits
    do_reset();
    set_req(0, 1, 8'hB0, 0);
    set_req(1, 1, 8'h91, 1);
    do_grant(0);
    step();
    set_req(0, 0, 8'h00, 0);
    #1;
    for (int c = 0; c < 5; c++) begin
      chk("pause_valid", bus.tx_valid, 0);
      chk("pause_grant", bus.grant_id, 0);
      chk("pause_ready1", bus.req_ready[1], 0);
      step();
    end
    set_req(0, 1, 8'hB1, 1);
    #1;
    chk("pause_resume", bus.tx_data, 8'hB1);
    step();
    set_req(0, 0, 8'h00, 0);
    do_grant(1);
    chk("pause_next", bus.tx_data, 8'h91);
    // backpressure: byte held stable for 10 cycles, one transfer afterwards
    do_reset();
    set_req(0, 1, 8'h5A, 1);
    do_grant(0);
    bus.tx_ready = 1'b0;
    #1;
    n0 = xfers;
    for (int c = 0; c < 10; c++) begin
      chk("stall_valid", bus.tx_valid, 1);
      chk("stall_data", bus.tx_data, 8'h5A);
      chk("stall_ready", bus.req_ready, 0);
      step();
    end
    bus.tx_ready = 1'b1;
    #1;
    chk("stall_go_ready", bus.req_ready, 4'b0001);
    step();
    set_req(0, 0, 8'h00, 0);
    #1;
    chk("stall_one_xfer", xfers - n0, 1);
    chk("stall_busy", bus.busy, 0);
`ifdef UART_ARB_HDR_EN
    do_reset();
    set_req(3, 1, 8'h01, 1);
    do_grant(3);
    chk("hdr_payload", bus.tx_data, 8'h01);
    step();
    step();
    chk("hdr_again", bus.tx_data, 8'hA3);
    rst = 1'b1;
    step();
    chk("hdr_rst_valid", bus.tx_valid, 0);
    chk("hdr_rst_busy", bus.busy, 0);
    rst = 1'b0;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
